// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: bus bundle between two ALU requesters, the shared ALU and the response consumer.
// slave  : arbiter side (takes requests, drives the ALU, returns the response)
// master : environment side (requesters, ALU model, response consumer)
interface alu_share_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_operand_a;
    logic [DATA_WIDTH-1:0] req0_operand_b;
    logic [CTRL_WIDTH-1:0] req0_alu_control;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_operand_a;
    logic [DATA_WIDTH-1:0] req1_operand_b;
    logic [CTRL_WIDTH-1:0] req1_alu_control;
    logic [DATA_WIDTH-1:0] alu_operand_a;
    logic [DATA_WIDTH-1:0] alu_operand_b;
    logic [CTRL_WIDTH-1:0] alu_control;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_result;
    logic                  resp_zero;
    logic                  resp_id;

    modport slave (
        input  req0_valid, req0_operand_a, req0_operand_b, req0_alu_control,
        input  req1_valid, req1_operand_a, req1_operand_b, req1_alu_control,
        input  alu_result, alu_zero, resp_ready,
        output req0_ready, req1_ready,
        output alu_operand_a, alu_operand_b, alu_control,
        output resp_valid, resp_result, resp_zero, resp_id
    );

    modport master (
        output req0_valid, req0_operand_a, req0_operand_b, req0_alu_control,
        output req1_valid, req1_operand_a, req1_operand_b, req1_alu_control,
        output alu_result, alu_zero, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_operand_a, alu_operand_b, alu_control,
        input  resp_valid, resp_result, resp_zero, resp_id
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters (accept -> execute -> respond).
// clk, rst_n (async active-low); bus: requester handshakes, shared ALU operands/result, tagged response.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  id_q, id_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_zero_q, resp_zero_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0] resp_result_q, resp_result_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic                  gnt0, gnt1;
    // ptr_q=1 favours requester 1 when both are valid
    assign gnt1 = bus.req1_valid & (~bus.req0_valid | ptr_q);
    assign gnt0 = bus.req0_valid & ~gnt1;
    assign bus.req0_ready    = (state_q == IDLE) & gnt0;
    assign bus.req1_ready    = (state_q == IDLE) & gnt1;
    assign bus.alu_operand_a = op_a_q;
    assign bus.alu_operand_b = op_b_q;
    assign bus.alu_control   = ctrl_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_result   = resp_result_q;
    assign bus.resp_zero     = resp_zero_q;
    assign bus.resp_id       = id_q;
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        ctrl_d        = ctrl_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
        unique case (state_q)
            IDLE: if (gnt0 | gnt1) begin
                op_a_d  = gnt1 ? bus.req1_operand_a : bus.req0_operand_a;
                op_b_d  = gnt1 ? bus.req1_operand_b : bus.req0_operand_b;
                ctrl_d  = gnt1 ? bus.req1_alu_control : bus.req0_alu_control;
                id_d    = gnt1;
                state_d = EXEC;
            end
            EXEC: begin
                resp_result_d = bus.alu_result;
                resp_zero_d   = bus.alu_zero;
                resp_valid_d  = 1'b1;
                state_d       = RESP;
            end
            RESP: if (bus.resp_ready) begin
                resp_valid_d = 1'b0;
                ptr_d        = ~id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= 1'b0;
            id_q          <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            ctrl_q        <= '0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            id_q          <= id_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            ctrl_q        <= ctrl_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: table vectors, hand sequences and randomized rounds against a transaction-level model.
module tb_alu_share_arbiter;
    localparam int DW = 32;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    alu_share_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus();
    alu_share_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    int n_vec = 0;
    int n_err = 0;
    function automatic logic [DW-1:0] ref_alu(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (c)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b1000: return a | b;
            4'b1001: return a & b;
            default: return a ^ b;
        endcase
    endfunction
    assign bus.alu_result = ref_alu(bus.alu_control, bus.alu_operand_a, bus.alu_operand_b);
    assign bus.alu_zero   = (bus.alu_result == '0);
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask
    task automatic set_req(input logic id, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] c);
        if (id) begin
            bus.req1_valid = v; bus.req1_operand_a = a; bus.req1_operand_b = b; bus.req1_alu_control = c;
        end else begin
            bus.req0_valid = v; bus.req0_operand_a = a; bus.req0_operand_b = b; bus.req0_alu_control = c;
        end
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, '0, '0, '0);
        set_req(1'b1, 1'b0, '0, '0, '0);
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask
    task automatic wait_ready(input logic id);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ready_seen", {63'd0, ok}, 64'd1);
    endtask
    // starts and ends at posedge+1 with the arbiter idle; operands are scrambled the cycle after the handshake
    task automatic do_op(input string nm, input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [CW-1:0] c, input logic [DW-1:0] res, input logic z);
        set_req(id, 1'b1, a, b, c);
        bus.resp_ready = 1'b1;
        wait_ready(id);
        @(posedge clk); #1;
        set_req(id, 1'b0, ~a, b + 32'd7, ~c);
        @(negedge clk);
        chk({nm, "_ready_pulse"}, {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        chk({nm, "_alu_ab"}, {bus.alu_operand_a, bus.alu_operand_b}, {a, b});
        chk({nm, "_alu_ctrl"}, {60'd0, bus.alu_control}, {60'd0, c});
        chk({nm, "_exec_valid"}, {63'd0, bus.resp_valid}, 64'd0);
        @(negedge clk);
        chk({nm, "_resp_valid"}, {63'd0, bus.resp_valid}, 64'd1);
        chk({nm, "_resp"}, {30'd0, bus.resp_result, bus.resp_zero, bus.resp_id}, {30'd0, res, z, id});
        @(posedge clk); #1;
    endtask
    typedef struct {
        logic          id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [CW-1:0] c;
        logic [DW-1:0] res;
        logic          z;
    } vec_t;
    vec_t vt[8];
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [DW-1:0] ra[2];
        logic [DW-1:0] rb[2];
        logic [CW-1:0] rc[2];
        logic [CW-1:0] codes[4];
        logic [DW-1:0] exp_res;
        logic          fav, exp_id, v0, v1, found;
        int            got, stall;
        vt[0] = '{1'b0, 32'd11, 32'd12, 4'b0000, 32'd23, 1'b0};
        vt[1] = '{1'b1, 32'd20, 32'd20, 4'b0001, 32'd0, 1'b1};
        vt[2] = '{1'b1, 32'd20, 32'd15, 4'b0001, 32'd5, 1'b0};
        vt[3] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, 1'b1};
        vt[4] = '{1'b1, 32'h1234_0000, 32'h0000_5678, 4'b1000, 32'h1234_5678, 1'b0};
        vt[5] = '{1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b1001, 32'h0F00_0F00, 1'b0};
        vt[6] = '{1'b1, 32'd0, 32'd1, 4'b0001, 32'hFFFF_FFFF, 1'b0};
        vt[7] = '{1'b0, 32'hAAAA_5555, 32'hAAAA_5555, 4'b0110, 32'd0, 1'b1};
        codes = '{4'b0000, 4'b0001, 4'b1000, 4'b1001};
        do_reset();
        @(negedge clk);
        chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("rst_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        chk("rst_alu", {bus.alu_operand_a, bus.alu_operand_b}, 64'd0);
        chk("rst_resp", {30'd0, bus.resp_result, bus.resp_zero, bus.resp_id}, 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++)
            do_op($sformatf("vec%0d", i), vt[i].id, vt[i].a, vt[i].b, vt[i].c, vt[i].res, vt[i].z);
        // both held valid: grants alternate 0,1,0,1
        do_reset();
        set_req(1'b0, 1'b1, 32'h0F0F, 32'hF0F0, 4'b1001);
        set_req(1'b1, 1'b1, 32'h0F0F, 32'hF0F0, 4'b1000);
        bus.resp_ready = 1'b1;
        got = 0;
        for (int cy = 0; cy < 40 && got < 4; cy++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                chk($sformatf("alt_id%0d", got), {63'd0, bus.resp_id}, 64'(got % 2));
                chk($sformatf("alt_res%0d", got), {31'd0, bus.resp_result, bus.resp_zero},
                    (got % 2) ? {31'd0, 32'h0000_FFFF, 1'b0} : {31'd0, 32'h0, 1'b1});
                got++;
            end
        end
        chk("alt_count", 64'(got), 64'd4);
        // backpressure in RESP with both requesters valid
        do_reset();
        set_req(1'b0, 1'b1, 32'h0F0F, 32'hF0F0, 4'b1001);
        set_req(1'b1, 1'b1, 32'h0F0F, 32'hF0F0, 4'b1000);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("bp_resp_seen", {63'd0, found}, 64'd1);
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            chk("bp_resp", {29'd0, bus.resp_valid, bus.resp_result, bus.resp_zero, bus.resp_id},
                {29'd0, 1'b1, 32'd0, 1'b1, 1'b0});
            chk("bp_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
            chk("bp_alu", {bus.alu_operand_a, bus.alu_operand_b}, {32'h0F0F, 32'hF0F0});
            chk("bp_ctrl", {60'd0, bus.alu_control}, {60'd0, 4'b1001});
        end
        @(posedge clk); #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        @(negedge clk);
        chk("bp_next_grant", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd2);
        // reset during EXEC drops the op and restores the pointer to req0
        do_reset();
        do_op("pre_rst", 1'b0, 32'd11, 32'd12, 4'b0000, 32'd23, 1'b0);
        set_req(1'b1, 1'b1, 32'd9, 32'd3, 4'b0001);
        wait_ready(1'b1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, '0, '0, '0);
        rst_n = 1'b0;
        #1;
        chk("rst_exec_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("rst_exec_alu", {bus.alu_operand_a, bus.alu_operand_b}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_resp", {63'd0, bus.resp_valid}, 64'd0);
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 32'd1, 32'd2, 4'b0000);
        set_req(1'b1, 1'b1, 32'd3, 32'd4, 4'b0000);
        @(negedge clk);
        chk("rst_ptr_grant", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd1);
        // randomized rounds against a round-robin transaction model
        do_reset();
        fav = 1'b0;
        for (int r = 0; r < 60; r++) begin
            {v1, v0} = 2'($urandom_range(1, 3));
            for (int j = 0; j < 2; j++) begin
                ra[j] = $urandom;
                rb[j] = ($urandom_range(0, 3) == 0) ? ra[j] : $urandom;
                rc[j] = ($urandom_range(0, 4) == 4) ? 4'($urandom) : codes[$urandom_range(0, 3)];
            end
            set_req(1'b0, v0, ra[0], rb[0], rc[0]);
            set_req(1'b1, v1, ra[1], rb[1], rc[1]);
            bus.resp_ready = 1'b0;
            exp_id = (v0 && v1) ? fav : v1;
            exp_res = ref_alu(rc[exp_id], ra[exp_id], rb[exp_id]);
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if ((bus.req0_ready | bus.req1_ready) === 1'b1) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("rnd_gnt", {62'd0, bus.req1_ready, bus.req0_ready}, exp_id ? 64'd2 : 64'd1);
            if (!found) break;
            @(posedge clk); #1;
            set_req(1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
            set_req(1'b1, 1'($urandom), $urandom, $urandom, 4'($urandom));
            found = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (bus.resp_valid === 1'b1) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("rnd_resp_seen", {63'd0, found}, 64'd1);
            chk("rnd_resp", {30'd0, bus.resp_result, bus.resp_zero, bus.resp_id},
                {30'd0, exp_res, (exp_res == '0), exp_id});
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                set_req(1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
                set_req(1'b1, 1'($urandom), $urandom, $urandom, 4'($urandom));
                @(negedge clk);
                chk("rnd_stall_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
                chk("rnd_stall_resp", {29'd0, bus.resp_valid, bus.resp_result, bus.resp_zero, bus.resp_id},
                    {29'd0, 1'b1, exp_res, (exp_res == '0), exp_id});
            end
            @(posedge clk); #1 bus.resp_ready = 1'b1;
            @(negedge clk);
            chk("rnd_last_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
            @(posedge clk); #1;
            fav = ~exp_id;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
